// File: rtl/m_unit.sv
// rtl/m_unit.sv - RV32M multi-cycle execute unit: registered 33x33 multiply and radix-2 restoring divide

package m_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_e;

    typedef struct packed {
        logic [31:0] a_i;
        logic [31:0] b_i;
        m_op_e       op;
    } M_req_t;

endpackage

module m_unit
    import m_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  M_req_t      req_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e      state;
    state_e      state_nxt;

    logic [31:0] a_q;
    logic [31:0] b_q;
    m_op_e       op_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [4:0]  cnt_q;
    logic [31:0] rsp_data_q;

    // Request decode (op[2]=divide family, op[0]=unsigned divide, op[1]=remainder)
    logic        accept;
    logic        req_is_mul;
    logic        req_signed;
    logic        req_is_rem;
    logic        req_div_zero;
    logic        req_div_ovf;
    logic [31:0] req_a_mag;
    logic [31:0] req_b_mag;

    always_comb begin
        req_is_mul   = ~req_i.op[2];
        req_signed   = ~req_i.op[0];
        req_is_rem   = req_i.op[1];
        req_div_zero = (req_i.b_i == 32'd0);
        req_div_ovf  = req_signed && (req_i.a_i == 32'h8000_0000) && (req_i.b_i == 32'hFFFF_FFFF);
        req_a_mag    = (req_signed && req_i.a_i[31]) ? -req_i.a_i : req_i.a_i;
        req_b_mag    = (req_signed && req_i.b_i[31]) ? -req_i.b_i : req_i.b_i;
        accept       = req_valid_i && req_ready_o;
    end

    // Multiply: 33-bit extended operands, sign-extended to 64 bits so the
    // low 64 bits of the unsigned product equal the signed product.
    logic [32:0] mul_a_ext;
    logic [32:0] mul_b_ext;
    logic [63:0] mul_a_wide;
    logic [63:0] mul_b_wide;
    logic [63:0] mul_prod;
    logic [31:0] mul_result;

    always_comb begin
        mul_a_ext  = (op_q == OP_MULHU) ? {1'b0, a_q} : {a_q[31], a_q};
        mul_b_ext  = ((op_q == OP_MUL) || (op_q == OP_MULH)) ? {b_q[31], b_q} : {1'b0, b_q};
        mul_a_wide = {{31{mul_a_ext[32]}}, mul_a_ext};
        mul_b_wide = {{31{mul_b_ext[32]}}, mul_b_ext};
        mul_prod   = mul_a_wide * mul_b_wide;
        mul_result = (op_q == OP_MUL) ? mul_prod[31:0] : mul_prod[63:32];
    end

    // One restoring divide step; the shifted remainder keeps its carry bit
    // so divisors with bit 31 set still compare correctly.
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_nxt;
    logic [31:0] quot_nxt;
    logic        div_signed;
    logic        neg_quot;
    logic        neg_rem;
    logic [31:0] div_result;

    always_comb begin
        rem_shift  = {rem_q, dividend_q[31]};
        rem_ge     = (rem_shift >= {1'b0, divisor_q});
        rem_nxt    = rem_ge ? (rem_shift[31:0] - divisor_q) : rem_shift[31:0];
        quot_nxt   = {quot_q[30:0], rem_ge};
        div_signed = ~op_q[0];
        neg_quot   = div_signed && (a_q[31] ^ b_q[31]);
        neg_rem    = div_signed && a_q[31];
        if (op_q[1]) begin
            div_result = neg_rem ? -rem_nxt : rem_nxt;
        end else begin
            div_result = neg_quot ? -quot_nxt : quot_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_is_mul) begin
                        state_nxt = S_MUL;
                    end else if (req_div_zero || req_div_ovf) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: state_nxt = S_DONE;
            S_DIV: begin
                if (cnt_q == 5'd31) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath is frozen during a flush so a discarded result never reaches rsp_data_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_MUL;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else if (!flush_i) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q  <= req_i.a_i;
                        b_q  <= req_i.b_i;
                        op_q <= req_i.op;
                        if (!req_is_mul) begin
                            if (req_div_zero) begin
                                rsp_data_q <= req_is_rem ? req_i.a_i : 32'hFFFF_FFFF;
                            end else if (req_div_ovf) begin
                                rsp_data_q <= req_is_rem ? 32'd0 : 32'h8000_0000;
                            end else begin
                                dividend_q <= req_a_mag;
                                divisor_q  <= req_b_mag;
                                rem_q      <= '0;
                                quot_q     <= '0;
                                cnt_q      <= '0;
                            end
                        end
                    end
                end
                S_MUL: begin
                    rsp_data_q <= mul_result;
                end
                S_DIV: begin
                    dividend_q <= {dividend_q[30:0], 1'b0};
                    rem_q      <= rem_nxt;
                    quot_q     <= quot_nxt;
                    cnt_q      <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        rsp_data_q <= div_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state == S_IDLE) && !flush_i;
    assign rsp_valid_o = (state == S_DONE);
    assign busy_o      = (state != S_IDLE);
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_m_unit.sv
// tb/tb_m_unit.sv - directed self-checking bench for m_unit
module tb_m_unit;
    import m_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    M_req_t      req = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    m_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_i       (req),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a request at a negedge and return just after the accept edge.
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input m_op_e op);
        @(negedge clk);
        req.a_i   = a;
        req.b_i   = b;
        req.op    = op;
        req_valid = 1'b1;
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to rsp_valid, check data, then handshake.
    task automatic wait_rsp(input string tag, input logic [31:0] exp_data, input int exp_lat);
        int lat;
        logic busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, rsp_data, exp_data);
        chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle after rsp"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input m_op_e op, input logic [31:0] exp_data, input int exp_lat);
        issue(tag, a, b, op);
        wait_rsp(tag, exp_data, exp_lat);
    endtask

    initial begin
        logic bad;
        int seen;

        // Reset state
        #12;
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("req_ready after reset", {31'd0, req_ready}, 32'd1);

        // Multiplies
        run_op("MULH min*min", 32'h8000_0000, 32'h8000_0000, OP_MULH, 32'h4000_0000, 2);
        run_op("MULHSU -1*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHSU, 32'hFFFF_FFFF, 2);
        run_op("MULHU max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHU, 32'hFFFF_FFFE, 2);
        run_op("MUL 7*-3", 32'd7, 32'hFFFF_FFFD, OP_MUL, 32'hFFFF_FFEB, 2);

        // Divides
        run_op("DIV -7/2", 32'hFFFF_FFF9, 32'd2, OP_DIV, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2", 32'hFFFF_FFF9, 32'd2, OP_REM, 32'hFFFF_FFFF, 33);
        run_op("DIVU 100/7", 32'd100, 32'd7, OP_DIVU, 32'd14, 33);
        run_op("REMU 100/7", 32'd100, 32'd7, OP_REMU, 32'd2, 33);
        run_op("DIVU big/big", 32'hFFFF_FFFF, 32'h8000_0001, OP_DIVU, 32'd1, 33);

        // Special cases
        run_op("DIVU 5/0", 32'd5, 32'd0, OP_DIVU, 32'hFFFF_FFFF, 1);
        run_op("REMU 5/0", 32'd5, 32'd0, OP_REMU, 32'd5, 1);
        run_op("DIV ovf", 32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 32'h8000_0000, 1);
        run_op("REM ovf", 32'h8000_0000, 32'hFFFF_FFFF, OP_REM, 32'd0, 1);
        run_op("REM -5/0", 32'hFFFF_FFFB, 32'd0, OP_REM, 32'hFFFF_FFFB, 1);

        // Backpressure with a pending request
        issue("bp MUL", 32'd3, 32'd5, OP_MUL);
        @(negedge clk);
        chk("bp cycle1 rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("bp cycle2 rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp data", rsp_data, 32'd15);
        req.a_i   = 32'd6;
        req.b_i   = 32'd7;
        req.op    = OP_MUL;
        req_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_data !== 32'd15 || req_ready !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
        end
        chk("bp hold stable", {31'd0, bad}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp idle after release", {30'd0, busy, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp("bp pending MUL 6*7", 32'd42, 2);

        // Flush during divide iteration 10
        issue("flush DIVU", 32'd1000, 32'd3, OP_DIVU);
        repeat (10) @(posedge clk);
        #1;
        flush     = 1'b1;
        req.a_i   = 32'd100;
        req.b_i   = 32'd100;
        req.op    = OP_MUL;
        req_valid = 1'b1;
        #1 chk("flush req_ready low", {31'd0, req_ready}, 32'd0);
        chk("flush still busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post flush state", {29'd0, req_ready, busy, rsp_valid}, 32'd4);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("no response after flush", seen, 0);
        chk("flush keeps rsp_data", rsp_data, 32'd42);
        run_op("MUL 3*4 after flush", 32'd3, 32'd4, OP_MUL, 32'd12, 2);

        // Asynchronous reset mid-divide
        issue("rst DIV", 32'd50, 32'd5, OP_DIV);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async rst rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("DIVU 9/3 after rst", 32'd9, 32'd3, OP_DIVU, 32'd3, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_unit.md
# m_unit

Multi-cycle RV32M execute unit. Accepts one `M_req_t` (rs1, rs2, `m_op_e`) from the issue stage over a valid/ready handshake. Computes MUL/MULH/MULHSU/MULHU with a registered 33x33 signed multiply, and DIV/DIVU/REM/REMU with a 32-iteration radix-2 restoring divider. Returns the 32-bit result to writeback over a second valid/ready handshake. Sits between decode/issue and writeback, in parallel with the base ALU.

## Interface
- No parameters (XLEN fixed at 32).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous pipeline flush; aborts any op in flight.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  unit can accept a request.
- `req_i`  in  `M_req_t`  fields: `a_i` (rs1), `b_i` (rs2), `op`.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  writeback accepts result.
- `rsp_data_o`  out  32  result.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset forces IDLE.
- Reset values: `rsp_valid_o`=0, `rsp_data_o`=0, `busy_o`=0, all internal registers 0. `req_ready_o` is 1 as soon as reset deasserts.
- `req_ready_o` = (state==IDLE) & ~`flush_i`.
- An accept occurs when `req_valid_i` & `req_ready_o` are both high at a clock edge. On accept, the unit latches a, b and op.
- IDLE transitions on accept:
  - mul op: go to MUL.
  - div op, divisor==0: go to DONE. Result is quotient 0xFFFFFFFF, remainder = a.
  - signed div op with a==0x80000000 and b==0xFFFFFFFF: go to DONE. Result is quotient 0x80000000, remainder 0.
  - any other div op: go to DIV. Load |a| (signed ops) or a (unsigned ops), load |b| or b, clear partial remainder, set iteration counter to 0.
- MUL: one cycle. Operand extension to 33 bits:
  - MUL/MULH: both signed.
  - MULHSU: a signed, b zero-extended.
  - MULHU: both zero-extended.
  - Product is 66-bit signed. MUL takes bits [31:0]; the other three take bits [63:32]. Result registers into `rsp_data_o`, then go to DONE.
- DIV: one restoring iteration per cycle.
  - Step: rem = {rem[30:0], dividend MSB}; shift the dividend left; if rem >= divisor then subtract and set quotient bit 1.
  - The counter runs 0..31. At iteration 31, sign correction is applied and the result registers, then go to DONE.
  - Sign correction (signed ops only): quotient is negated iff sign(a) != sign(b). Remainder takes the sign of a.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE: `rsp_valid_o`=1 and `rsp_data_o` is held stable. When `rsp_ready_i`=1 at a clock edge, go to IDLE and `rsp_valid_o` falls. No new request is accepted in DONE.
- `flush_i` has highest priority in every state. At the next edge: state becomes IDLE, `rsp_valid_o` becomes 0, and the pending result is discarded. A request offered in the flush cycle is not accepted.
- `rst_i` mid-operation: immediate return to IDLE with all outputs at their reset values. No response is produced.

## Timing
- Cycle 0 is the accept edge.
- MUL ops: `rsp_valid_o` high from cycle 2 (latency 2).
- Normal div ops: `rsp_valid_o` high from cycle 33 (latency 33).
- Div-by-zero and overflow div ops: `rsp_valid_o` high from cycle 1 (latency 1).
- Earliest next accept is the cycle after the response handshake edge. Minimum issue interval: 3 cycles (mul) or 34 cycles (div).
- `rsp_data_o` changes only on the edge entering DONE, or on reset.

## Test plan
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL 7 x -3 -> 0xFFFFFFEB. Each response has `rsp_valid_o` at cycle 2.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each response has `rsp_valid_o` at cycle 33 and `busy_o` high for cycles 1-33.
- Special cases at cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles after a MUL result. `rsp_data_o` must stay stable, `req_ready_o` must stay 0, and a pending `req_valid_i` must not be accepted. Release `rsp_ready_i`: IDLE next cycle, then the pending request is accepted.
- Flush during DIV iteration 10:
  - No response is produced.
  - `req_ready_o`=1 the next cycle.
  - A following MUL 3 x 4 returns 12 correctly.
  - A request offered together with `flush_i` is ignored.
- Assert `rst_i` asynchronously mid-DIV. Outputs clear immediately (`busy_o`=0, `rsp_valid_o`=0). After deassertion, a DIVU 9/3 returns 3 with no stale state.
